// File: rtl/boxcar_decimator_pkg.sv
// rtl/boxcar_decimator_pkg.sv - shared width derivations for the pt_feedback conditioning chain
package boxcar_decimator_pkg;

   localparam int DEF_INPUT_WIDTH    = 14;
   localparam int DEF_OUTPUT_WIDTH   = 17;
   localparam int DEF_MAX_LOG2_RATIO = 8;

   function automatic int acc_width(input int input_width, input int max_log2_ratio);
      return input_width + max_log2_ratio;
   endfunction

   function automatic int gain_shift(input int output_width, input int input_width);
      return output_width - input_width;
   endfunction

   // Width of the log2-ratio control, sized to hold every legal L after clamping.
   function automatic int ratio_width(input int max_log2_ratio);
      return (max_log2_ratio < 1) ? 1 : $clog2(max_log2_ratio + 1);
   endfunction

endpackage

// File: rtl/boxcar_decimator_output_holdoff_reg.sv
// rtl/boxcar_decimator_output_holdoff_reg.sv - busy-gated result holding register with guard cycle
module output_holdoff_reg
   import boxcar_decimator_pkg::*;
#(
   parameter int WIDTH = DEF_OUTPUT_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    clear_i,
   input  logic                    load_i,
   input  logic signed [WIDTH-1:0] load_data_i,
   input  logic                    busy_i,
   output logic signed [WIDTH-1:0] data_o,
   output logic                    valid_o,
   output logic                    overrun_o
);

   logic                    pending;
   logic signed [WIDTH-1:0] pending_data;
   logic                    issue;

   // A strobe is never followed directly by another, giving the consumer time to raise busy.
   assign issue = pending && !busy_i && !valid_o;

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         pending      <= 1'b0;
         pending_data <= '0;
         data_o       <= '0;
         valid_o      <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         valid_o <= issue;
         if (issue) begin
            data_o <= pending_data;
         end
         if (load_i) begin
            pending      <= 1'b1;
            pending_data <= load_data_i;
            if (pending && !issue) begin
               overrun_o <= 1'b1;
            end
         end else if (issue) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/boxcar_decimator.sv
// rtl/boxcar_decimator.sv - run-time selectable 2^L boxcar average feeding the biquad chain
module boxcar_decimator
   import boxcar_decimator_pkg::*;
#(
   parameter int INPUT_WIDTH    = DEF_INPUT_WIDTH,
   parameter int OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
   parameter int MAX_LOG2_RATIO = DEF_MAX_LOG2_RATIO
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   reinit_i,
   input  logic signed [INPUT_WIDTH-1:0]          data_i,
   input  logic                                   data_valid_i,
   input  logic [ratio_width(MAX_LOG2_RATIO)-1:0] log2_ratio_i,
   input  logic                                   downstream_busy_i,
   output logic signed [OUTPUT_WIDTH-1:0]         data_o,
   output logic                                   data_valid_o,
   output logic                                   overrun_o
);

   localparam int ACC_WIDTH = acc_width(INPUT_WIDTH, MAX_LOG2_RATIO);
   localparam int G         = gain_shift(OUTPUT_WIDTH, INPUT_WIDTH);
   localparam int RW        = ratio_width(MAX_LOG2_RATIO);
   localparam int CNT_W     = (MAX_LOG2_RATIO > 0) ? MAX_LOG2_RATIO : 1;
   localparam int WIDE_W    = ACC_WIDTH + G;

   logic                           clear;
   logic [RW-1:0]                  ratio_req;
   logic [RW-1:0]                  l_q;
   logic [RW-1:0]                  l_eff;
   logic [CNT_W-1:0]               cnt;
   logic [CNT_W:0]                 cnt_last;
   logic                           block_done;
   logic signed [ACC_WIDTH-1:0]    acc;
   logic signed [ACC_WIDTH-1:0]    sum;
   logic signed [WIDE_W-1:0]       wide;
   logic signed [WIDE_W-1:0]       shifted;
   logic signed [OUTPUT_WIDTH-1:0] result;

   assign clear     = rst_i || reinit_i;
   assign ratio_req = (log2_ratio_i > RW'(MAX_LOG2_RATIO)) ? RW'(MAX_LOG2_RATIO) : log2_ratio_i;

   // The first sample of a block uses the live request; later samples use the latched L.
   assign l_eff      = (cnt == '0) ? ratio_req : l_q;
   assign cnt_last   = (CNT_W+1)'((32'd1 << l_eff) - 32'd1);
   assign block_done = data_valid_i && ({1'b0, cnt} == cnt_last);

   assign sum     = acc + ACC_WIDTH'(data_i);
   assign wide    = WIDE_W'(sum) <<< G;
   assign shifted = wide >>> l_eff;
   assign result  = shifted[OUTPUT_WIDTH-1:0];

   always_ff @(posedge clk_i) begin
      if (clear) begin
         acc <= '0;
         cnt <= '0;
         l_q <= '0;
      end else if (data_valid_i) begin
         if (cnt == '0) begin
            l_q <= ratio_req;
         end
         if (block_done) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   output_holdoff_reg #(
      .WIDTH(OUTPUT_WIDTH)
   ) u_holdoff (
      .clk_i      (clk_i),
      .clear_i    (clear),
      .load_i     (block_done),
      .load_data_i(result),
      .busy_i     (downstream_busy_i),
      .data_o     (data_o),
      .valid_o    (data_valid_o),
      .overrun_o  (overrun_o)
   );

endmodule

// File: tb/tb_boxcar_decimator.sv
// tb/tb_boxcar_decimator.sv - directed self-checking bench for boxcar_decimator
module tb_boxcar_decimator;

   logic               clk;
   logic               rst;
   logic               reinit;
   logic signed [13:0] data;
   logic               dvalid;
   logic [3:0]         ratio;
   logic               busy;
   logic [16:0]        data_o;
   logic               data_valid_o;
   logic               overrun_o;

   int tests;
   int fails;
   int pulse_cnt;
   int adj_cnt;
   int p0;
   int a0;
   logic prev_valid;
   logic [16:0] last_data;

   boxcar_decimator dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .reinit_i         (reinit),
      .data_i           (data),
      .data_valid_i     (dvalid),
      .log2_ratio_i     (ratio),
      .downstream_busy_i(busy),
      .data_o           (data_o),
      .data_valid_o     (data_valid_o),
      .overrun_o        (overrun_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      pulse_cnt  = 0;
      adj_cnt    = 0;
      prev_valid = 1'b0;
      last_data  = '0;
   end

   always @(negedge clk) begin
      if (data_valid_o === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         last_data = data_o;
         if (prev_valid === 1'b1) adj_cnt = adj_cnt + 1;
      end
      prev_valid = data_valid_o;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [13:0] v);
      data   = v;
      dvalid = 1'b1;
      tick();
      dvalid = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests = tests + 1;
      assert (obs === exp)
      else begin
         fails = fails + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      rst    = 1'b1;
      reinit = 1'b0;
      data   = '0;
      dvalid = 1'b0;
      ratio  = 4'd0;
      busy   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_data", data_o, 0);
      chk("reset_valid", data_valid_o, 0);
      chk("reset_overrun", overrun_o, 0);

      // L=2 mean of 100..103
      ratio = 4'd2;
      p0 = pulse_cnt;
      send(14'd100); send(14'd101); send(14'd102); send(14'd103);
      chk("l2_not_yet", data_valid_o, 0);
      tick();
      chk("l2_strobe", data_valid_o, 1);
      chk("l2_data", data_o, 812);
      tick();
      chk("l2_strobe_single", data_valid_o, 0);
      tick();
      chk("l2_pulse_count", pulse_cnt - p0, 1);

      // L=1 truncation toward -inf
      ratio = 4'd1;
      send(14'h3FFF); send(14'd0);
      tick();
      chk("l1_neg_strobe", data_valid_o, 1);
      chk("l1_neg_data", data_o, 17'h1FFFC);

      // L=0 pass-through, every other cycle
      ratio = 4'd0;
      tick();
      p0 = pulse_cnt;
      for (int i = 0; i < 4; i++) begin
         send(14'h2000);
         tick();
         chk("l0_strobe", data_valid_o, 1);
         chk("l0_data", data_o, 17'h10000);
      end
      chk("l0_no_overrun", overrun_o, 0);
      tick();
      chk("l0_pulse_count", pulse_cnt - p0, 4);

      // busy held across a completion
      ratio = 4'd1;
      busy  = 1'b1;
      send(14'd30); send(14'd40);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("busy_hold_low", data_valid_o, 0);
      end
      busy = 1'b0;
      tick();
      chk("busy_release_strobe", data_valid_o, 1);
      chk("busy_release_data", data_o, 280);
      tick();
      chk("busy_release_single", data_valid_o, 0);
      chk("busy_data_held", data_o, 280);

      // two completions under busy -> overrun
      p0   = pulse_cnt;
      busy = 1'b1;
      send(14'd10); send(14'd10);
      chk("ovr_first_clean", overrun_o, 0);
      send(14'd20); send(14'd20);
      chk("ovr_set", overrun_o, 1);
      busy = 1'b0;
      tick();
      chk("ovr_strobe", data_valid_o, 1);
      chk("ovr_data_newest", data_o, 160);
      tick();
      tick();
      chk("ovr_sticky", overrun_o, 1);
      chk("ovr_pulse_count", pulse_cnt - p0, 1);
      reinit = 1'b1;
      tick();
      reinit = 1'b0;
      chk("reinit_data", data_o, 0);
      chk("reinit_valid", data_valid_o, 0);
      chk("reinit_overrun", overrun_o, 0);

      // L=0 back-to-back input
      ratio = 4'd0;
      a0 = adj_cnt;
      send(14'd1);
      chk("b2b_ovr_e1", overrun_o, 0);
      send(14'd2);
      chk("b2b_ovr_e2", overrun_o, 0);
      chk("b2b_first_strobe", data_valid_o, 1);
      chk("b2b_first_data", data_o, 8);
      send(14'd3);
      chk("b2b_ovr_e3", overrun_o, 1);
      send(14'd4); send(14'd5); send(14'd6);
      tick();
      tick();
      chk("b2b_no_adjacent", adj_cnt - a0, 0);
      reinit = 1'b1;
      tick();
      reinit = 1'b0;

      // L change mid-block
      ratio = 4'd2;
      send(14'd1); send(14'd2);
      ratio = 4'd1;
      send(14'd3);
      chk("lchg_not_done", data_valid_o, 0);
      send(14'd4);
      tick();
      chk("lchg_strobe", data_valid_o, 1);
      chk("lchg_data", data_o, 20);
      send(14'd6); send(14'd8);
      tick();
      chk("lnext_strobe", data_valid_o, 1);
      chk("lnext_data", data_o, 56);

      // rst discards a partial block
      ratio = 4'd2;
      send(14'd7); send(14'd7); send(14'd7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send(14'd50); send(14'd50); send(14'd50); send(14'd50);
      tick();
      chk("rst_partial_strobe", data_valid_o, 1);
      chk("rst_partial_data", data_o, 400);

      // request above maximum clamps to L=8
      tick();
      ratio = 4'd15;
      p0 = pulse_cnt;
      for (int i = 0; i < 255; i++) send(14'd1);
      tick();
      chk("clamp_no_early", pulse_cnt - p0, 0);
      send(14'd1);
      tick();
      chk("clamp_strobe", data_valid_o, 1);
      chk("clamp_data", data_o, 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/boxcar_decimator.md
# boxcar_decimator

Upstream conditioning stage for the pt_feedback biquad chain. It accumulates 2^L consecutive valid ADC samples and emits their mean, widened to the filter's input width, as a single-cycle valid strobe. The strobe is gated by the downstream filter's busy flag so no sample is issued while the filter is mid-computation. L is selectable at run time, which lowers the filter's effective sample rate and adds averaging gain.

## Interface
- INPUT_WIDTH, 14: signed ADC sample width.
- OUTPUT_WIDTH, 17: signed output width, ≥ INPUT_WIDTH; matches the filter input width. G = OUTPUT_WIDTH − INPUT_WIDTH.
- MAX_LOG2_RATIO, 8: largest supported L. Accumulator width ACC_WIDTH = INPUT_WIDTH + MAX_LOG2_RATIO.
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- reinit_i  in  1  synchronous clear, same effect as rst_i.
- data_i  in  INPUT_WIDTH  signed sample.
- data_valid_i  in  1  sample qualifier, one cycle per sample.
- log2_ratio_i  in  clog2(MAX_LOG2_RATIO+1)  requested L. Values above MAX_LOG2_RATIO are clamped to MAX_LOG2_RATIO.
- downstream_busy_i  in  1  busy flag from the filter.
- data_o  out  OUTPUT_WIDTH  signed mean; held between strobes.
- data_valid_o  out  1  single-cycle result strobe.
- overrun_o  out  1  sticky flag: an unissued result was overwritten.

## Operation
- Reset and reinit values: data_o=0, data_valid_o=0, overrun_o=0. Accumulator, sample counter and pending flag are cleared. This applies mid-block: the partial sum is discarded.
- L is latched from log2_ratio_i when the counter is 0 and a valid sample arrives. A block always completes using its latched L.
- On each valid sample the accumulator adds the sign-extended data_i and the counter increments.
- When the sample that completes the block (counter = 2^L − 1) arrives:
  - sum = acc + data_i;
  - result = (sum <<< G) >>> L, arithmetic shift, truncation toward −∞, taking the low OUTPUT_WIDTH bits;
  - result is written to the pending register and the pending flag is set;
  - accumulator and counter restart at 0 in the same edge.
- L=0 is pass-through: result = data_i <<< G.
- Issue rule: data_valid_o is asserted for the next cycle, and data_o loads the pending value, when all of these hold in the current cycle:
  - pending=1;
  - downstream_busy_i=0;
  - data_valid_o=0.
  On issue, pending clears.
- data_valid_o is never high on two consecutive cycles. This guard cycle covers the one-cycle delay before the filter raises busy.
- Completion while pending=1 and no issue that cycle: the pending value is overwritten with the newer result and overrun_o is set. overrun_o stays set until rst_i or reinit_i.
- Completion in the same cycle as an issue: the old value issues, the new result becomes pending, and no overrun is flagged.

## Timing
- Minimum latency: final sample at edge k, data_valid_o high in cycle k+1 → k+2, provided busy is low and no strobe was active.
  - Ready path: result is written to pending at edge k; the issue conditions are met in cycle k; data_valid_o rises at edge k+1.
- Held result: data_valid_o rises on the edge after the first cycle in which downstream_busy_i is sampled low.
- Peak output rate: one strobe every 2 cycles. Sustained input throughput is unlimited; excess results overrun.
- No combinational path from any input to any output.

## Structure
- Shared pt_feedback defines header holds:
  - the ACC_WIDTH and G derivations;
  - the clamped log2-ratio width function.
- One sub-module, output_holdoff_reg. It contains the pending register, the pending flag, the issue rule with its guard cycle, and overrun detection. It is reusable in front of any busy-gated stage.
- Accumulator and counter stay in the top level.

## Test plan
- L=2, busy=0, inputs 100,101,102,103 on consecutive cycles → sum 406, data_o=812, exactly one data_valid_o pulse, rising 1 cycle after the edge that captures 103.
- L=1, inputs −1, 0 → data_o=−4 (17-bit 0x1FFFC), showing truncation toward −∞. L=0, input −8192 every other cycle → data_o=−65536 on every strobe, no overrun.
- L=1, busy held high for 6 cycles across a completion → data_valid_o stays low; it rises 1 cycle after busy is first sampled low; data_o holds the mean.
- L=1, busy held high across two completions (means 10, then 20) → one strobe with data_o=160, overrun_o=1. overrun_o stays 1 until reinit_i, which clears all outputs the next cycle.
- L=0, valid every cycle, busy=0 → strobes never on adjacent cycles, and overrun_o sets on the first collision.
- log2_ratio_i changes 2→1 after 2 samples → that block still uses 4 samples; the next block uses 2. rst_i after 3 samples of a block, followed by 4 samples of 50 at L=2 → data_o=400.
